// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the switch input peripheral.
//   deb_state_t              : per-channel debounce FSM state
//   DEBOUNCE_CYCLES_DEFAULT  : 10 ms hold time at 50 MHz
//   IO_INPUT_BASE            : byte address of input channel 0 (channel i at +i)
// ----------------------------------------------------------------------------
package io_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } deb_state_t;

  localparam int          DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam logic [15:0] IO_INPUT_BASE           = 16'h1000;

endpackage

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One switch channel: 2-flop synchronizer, debounce FSM with hold counter,
// and optional registered edge pulses (built when SW_DEBOUNCE_EDGE_PULSE_EN
// is defined, otherwise the pulse outputs are tied low).
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high
//   raw_in     : asynchronous raw switch level
//   stable_out : debounced level (registered)
//   rise_pulse : one-cycle pulse coincident with stable_out 0->1
//   fall_pulse : one-cycle pulse coincident with stable_out 1->0
// ----------------------------------------------------------------------------
module debounce_channel
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic stable_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  // Width guarded so an illegal DEBOUNCE_CYCLES still elaborates and the
  // top-level assertion can report it.
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic           sync_p0;
  logic           sync_p1;
  deb_state_t     state;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      state      <= STABLE_LOW;
      cnt        <= '0;
      stable_out <= 1'b0;
`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
`endif
    end else begin
      // stage p0 -> p1: metastability filter on the raw level
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
`endif
      // FSM consumes only the second synchronizer flop
      case (state)
        STABLE_LOW: begin
          if (sync_p1) begin
            state <= PEND_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        STABLE_HIGH: begin
          if (!sync_p1) begin
            state <= PEND_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        PEND_HIGH: begin
          if (!sync_p1) begin
            // glitch: fall back without any pulse
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state      <= STABLE_HIGH;
            cnt        <= '0;
            stable_out <= 1'b1;
`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
            rise_pulse <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PEND_LOW: begin
          if (sync_p1) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state      <= STABLE_LOW;
            cnt        <= '0;
            stable_out <= 1'b0;
`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
            fall_pulse <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state      <= STABLE_LOW;
          cnt        <= '0;
          stable_out <= 1'b0;
        end
      endcase
    end
  end

`ifndef SW_DEBOUNCE_EDGE_PULSE_EN
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
// Debouncer for N_INPUTS slide switches; stable_out[i] feeds input byte
// IO_INPUT_BASE+i. Edge pulses and any_change exist only when
// SW_DEBOUNCE_EDGE_PULSE_EN is defined; otherwise they are tied to 0.
// Ports:
//   clk        : CLOCK_50, rising edge
//   reset      : asynchronous, active-high
//   raw_in     : [N_INPUTS] raw switch levels
//   stable_out : [N_INPUTS] debounced levels (registered)
//   rise_pulse : [N_INPUTS] one-cycle pulse on debounced 0->1
//   fall_pulse : [N_INPUTS] one-cycle pulse on debounced 1->0
//   any_change : OR of all rise/fall pulses
// ----------------------------------------------------------------------------
module sw_debounce
  import io_pkg::*;
#(
  parameter int N_INPUTS        = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] raw_in,
  output logic [N_INPUTS-1:0] stable_out,
  output logic [N_INPUTS-1:0] rise_pulse,
  output logic [N_INPUTS-1:0] fall_pulse,
  output logic                any_change
);

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw_in     (raw_in[i]),
      .stable_out (stable_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
  // Pulses are registered, so this OR lines up with them in the same cycle.
  assign any_change = |(rise_pulse | fall_pulse);
`else
  assign any_change = 1'b0;
`endif

  always @(posedge clk) begin
    assert (DEBOUNCE_CYCLES >= 1)
      else $error("sw_debounce: DEBOUNCE_CYCLES must be >= 1 (got %0d)", DEBOUNCE_CYCLES);
  end

endmodule

// File: tb/tb_sw_debounce.sv
// ----------------------------------------------------------------------------
// tb_sw_debounce
// Directed bench for sw_debounce with DEBOUNCE_CYCLES = 4, N_INPUTS = 10.
// Inputs change 1 ns after a rising edge; the next edge is the first that
// samples them, and a held change commits on the 7th edge after the change
// (first sampling edge + 2 + DEBOUNCE_CYCLES). Pulse expectations collapse to
// zero when SW_DEBOUNCE_EDGE_PULSE_EN is not defined.
// ----------------------------------------------------------------------------
module tb_sw_debounce;

  localparam int N = 10;
  localparam int D = 4;
`ifdef SW_DEBOUNCE_EDGE_PULSE_EN
  localparam bit EP = 1'b1;
`else
  localparam bit EP = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] raw_in;
  logic [N-1:0] stable_out;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic         any_change;

  int checks = 0;
  int errors = 0;

  sw_debounce #(
    .N_INPUTS        (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .stable_out (stable_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_change (any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // All outputs quiet and stable_out at a given value.
  task automatic check_quiet(input string tag, input logic [N-1:0] st);
    check({tag, ".stable"}, 32'(stable_out), 32'(st));
    check({tag, ".rise"},   32'(rise_pulse), 32'd0);
    check({tag, ".fall"},   32'(fall_pulse), 32'd0);
    check({tag, ".any"},    32'(any_change), 32'd0);
  endtask

  // Raw already applied just after an edge: 6 quiet edges, commit on the 7th,
  // pulses gone on the 8th.
  task automatic wait_commit(input string tag, input logic [N-1:0] prev,
                             input logic [N-1:0] fin, input logic [N-1:0] rise,
                             input logic [N-1:0] fall);
    for (int k = 1; k <= D + 2; k++) begin
      tick();
      check_quiet({tag, ".hold"}, prev);
    end
    tick();
    check({tag, ".commit.stable"}, 32'(stable_out), 32'(fin));
    check({tag, ".commit.rise"},   32'(rise_pulse), EP ? 32'(rise) : 32'd0);
    check({tag, ".commit.fall"},   32'(fall_pulse), EP ? 32'(fall) : 32'd0);
    check({tag, ".commit.any"},    32'(any_change), 32'(EP));
    tick();
    check_quiet({tag, ".after"}, fin);
  endtask

  task automatic hold_and_check(input string tag, input logic [N-1:0] new_raw,
                                input logic [N-1:0] prev, input logic [N-1:0] fin,
                                input logic [N-1:0] rise, input logic [N-1:0] fall);
    raw_in = new_raw;
    wait_commit(tag, prev, fin, rise, fall);
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = '0;

    // Reset state, including with inputs active during reset
    #1;
    check_quiet("reset.t0", 10'h000);
    raw_in = 10'h3FF;
    repeat (3) tick();
    check_quiet("reset.held", 10'h000);
    raw_in = 10'h000;
    repeat (3) tick();
    reset = 1'b0;

    // Release produces no pulses
    for (int k = 0; k < 8; k++) begin
      tick();
      check_quiet("release", 10'h000);
    end

    // Channel 0 rise after 6 edges
    hold_and_check("ch0.rise", 10'h001, 10'h000, 10'h001, 10'h001, 10'h000);

    // Channel 3 glitch of 3 cycles is rejected
    raw_in = 10'h009;
    repeat (3) tick();
    raw_in = 10'h001;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_quiet("ch3.glitch", 10'h001);
    end

    // Counter restarted from zero: full latency on channels 3 and 5
    hold_and_check("ch35.rise", 10'h029, 10'h001, 10'h029, 10'h028, 10'h000);

    // Channel 5 falls alone
    hold_and_check("ch5.fall", 10'h009, 10'h029, 10'h009, 10'h000, 10'h020);

    // Channels 0 and 3 fall together
    hold_and_check("ch03.fall", 10'h000, 10'h009, 10'h000, 10'h000, 10'h009);

    // All channels rise in the same cycle, any_change one cycle
    hold_and_check("all.rise", 10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h000);

    // All channels fall together
    hold_and_check("all.fall", 10'h000, 10'h3FF, 10'h000, 10'h000, 10'h3FF);

    // Reset two edges into PEND_HIGH on channel 1
    raw_in = 10'h002;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check_quiet("rst_pend.async", 10'h000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_quiet("rst_pend.held", 10'h000);
    end
    reset = 1'b0;
    // raw_in[1] still high: full latency from the first post-release edge
    wait_commit("rst_pend.rel", 10'h000, 10'h002, 10'h002, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
